// File: rtl/nibble_serial_adder.sv
// Serial adder: processes one 4-bit slice per clock, LSB first, with a rippled carry register.
// Optional macro NIBBLE_SERIAL_OVF_EN adds a signed-overflow output (ovf).
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy,
    output logic                 done
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic                 ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      an, bn;
    logic [4:0]      slice;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic            ovf_q, ovf_d;
    logic [3:0]      low3;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        an      = '0;
        bn      = '0;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                an = a_q[4*i +: 4];
                bn = b_q[4*i +: 4];
            end
        end
        slice = {1'b0, an} + {1'b0, bn} + {4'b0000, carry_q};
`ifdef NIBBLE_SERIAL_OVF_EN
        // bit 3 of low3 is the carry into the slice MSB
        low3  = {1'b0, an[2:0]} + {1'b0, bn[2:0]} + {3'b000, carry_q};
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CW'(i)) acc_d[4*i +: 4] = slice[3:0];
                end
                carry_d = slice[4];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = slice[4];
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef NIBBLE_SERIAL_OVF_EN
                    ovf_d   = low3[3] ^ slice[4];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
`ifdef NIBBLE_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors, expected results queued at issue.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst, start, cin;
    logic [15:0] a, b, sum;
    logic        cout, busy, done;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic        ovf;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef NIBBLE_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", 32'(busy), 32'd0);
`ifdef NIBBLE_SERIAL_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Issues one operation at the current negedge; returns at the negedge where done is expected.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo, input bit hold);
        exp_t e;
        a = ta; b = tb; cin = tc; start = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 5;
        q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            if (hold) begin
                a = 16'h0000; b = 16'h0000; cin = 1'b0;
                if (i == 3) start = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'h5556);
        chk("hold_cout", 32'(cout), 32'd0);

        run_op(16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("held_start_single", 32'(busy), 32'd0);

        // back-to-back: start during the DONE cycle
        run_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // abort on the 2nd RUN cycle
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(q.size()), 32'd0);

        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

`ifdef NIBBLE_SERIAL_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("pending_results", 32'(q.size()), 32'd0);
        chk("final_sum_hold", 32'(sum),
`ifdef NIBBLE_SERIAL_OVF_EN
            32'h0000
`else
            32'h0003
`endif
        );
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled on the clk rising edge.
REQ-005 The block SHALL have port a, input, W bits: first operand, unsigned.
REQ-006 The block SHALL have port b, input, W bits: second operand, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into nibble 0.
REQ-008 The block SHALL have port sum, output, W bits: registered result, low W bits of a+b+cin.
REQ-009 The block SHALL have port cout, output, 1 bit: registered carry out of the top nibble.
REQ-010 The block SHALL have port busy, output, 1 bit: high while nibbles are being processed.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum/cout valid.

Function
REQ-012 The block SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture a, b, cin into internal registers, clear the nibble counter to 0, and enter RUN.
REQ-014 start SHALL be ignored in RUN; a, b, cin SHALL NOT be sampled there.
REQ-015 Each RUN cycle SHALL add nibble k of the captured operands plus the carry register in one 4-bit ripple slice, store the 4-bit result into accumulator bits [4k+3:4k], store the slice carry into the carry register, and increment k.
REQ-016 Nibbles SHALL be processed LSB first; the carry register SHALL start at the captured cin.
REQ-017 On the edge processing nibble NIBBLES-1, the block SHALL load sum with the full accumulator, load cout with the slice carry, set done=1, and enter DONE.
REQ-018 Latency SHALL be exactly NIBBLES edges from the start-sampling edge to the edge raising done (4 for default).
REQ-019 done SHALL be high for exactly one cycle (the DONE state); DONE SHALL go to IDLE when start=0.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-021 sum and cout SHALL change only on the completion edge and SHALL hold their value until the next completion or reset.
REQ-022 Arithmetic SHALL be modulo 2^W; carry out of nibble k SHALL propagate only through the carry register into nibble k+1.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL enter IDLE and set sum=0, cout=0, busy=0, done=0, counter=0, carry register=0, accumulator=0.
REQ-024 rst SHALL take priority over start and abort an in-progress RUN without producing done.

Configuration
REQ-025 With macro NIBBLE_SERIAL_OVF_EN defined, the block SHALL add output ovf, 1 bit: signed two's-complement overflow of the W-bit add, computed from the final nibble (carry into bit W-1 XOR carry out of bit W-1), loaded and held like cout, reset to 0.
REQ-026 Without NIBBLE_SERIAL_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (NIBBLES=4)
REQ-027 a=16'hFFFF, b=16'h0001, cin=0, start pulse -> done high 4 edges later for one cycle; sum=16'h0000, cout=1; busy high for the 4 RUN cycles.
REQ-028 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; sum/cout unchanged until the next completion.
REQ-029 start held high through RUN while a/b are changed to 16'h0000 -> result still that of the captured operands; one done per accepted start.
REQ-030 rst=1 on the 2nd RUN cycle of a=16'hFFFF, b=16'hFFFF -> all outputs 0, no done; following start with a=16'h0001, b=16'h0002 -> sum=16'h0003.
REQ-031 start=1 during the DONE cycle with a=16'h00FF, b=16'h0001 -> immediate entry to RUN; done after 4 more edges with sum=16'h0100, cout=0.
REQ-032 With NIBBLE_SERIAL_OVF_EN: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0; a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
